// File: rtl/freq_meter_if.sv
// Result bus of the frequency meter: enable in, measurement out.
`timescale 1ns/1ps
interface freq_meter_if #(
    parameter int CNT_W = 27
);
    logic             enable;
    logic [CNT_W-1:0] freq_count;
    logic             count_valid;
    logic             overflow;
    logic             busy;

    modport master (
        output enable,
        input  freq_count,
        input  count_valid,
        input  overflow,
        input  busy
    );

    modport slave (
        input  enable,
        output freq_count,
        output count_valid,
        output overflow,
        output busy
    );
endinterface

// File: rtl/freq_meter.sv
// Counts rising edges of an asynchronous input over a gate window
// of GATE_CYCLES clk_100Mhz cycles and publishes the count.
`timescale 1ns/1ps
module freq_meter #(
    parameter int GATE_CYCLES = 100_000_000,
    parameter int CNT_W       = 27,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk_100Mhz,
    input  logic        rst,
    input  logic        sig_in,
    freq_meter_if.slave bus
);
    localparam int GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST =
        GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        DONE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;
    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic [CNT_W-1:0]       edge_nxt;
    logic                   ovf;
    logic                   ovf_nxt;
    logic [CNT_W-1:0]       freq_q;
    logic                   ovf_q;
    logic                   valid_q;
    logic                   busy_q;

    // History tracks the synchroniser in every state, so a level
    // already high when the gate opens is never seen as an edge.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_comb begin
        edge_nxt = edge_cnt;
        ovf_nxt  = ovf;
        if (rise) begin
            if (edge_cnt == CNT_MAX) begin
                ovf_nxt = 1'b1;
            end else begin
                edge_nxt = edge_cnt + 1'b1;
            end
        end
    end

    // The result is latched on entry to DONE so that freq_count
    // already holds the new value while count_valid is high.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
            freq_q   <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf      <= 1'b0;
                    if (bus.enable) begin
                        state  <= GATE;
                        busy_q <= 1'b1;
                    end
                end
                GATE: begin
                    if (!bus.enable) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        edge_cnt <= edge_nxt;
                        ovf      <= ovf_nxt;
                        if (gate_cnt == GATE_LAST) begin
                            state   <= DONE;
                            freq_q  <= edge_nxt;
                            ovf_q   <= ovf_nxt;
                            valid_q <= 1'b1;
                        end else begin
                            gate_cnt <= gate_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    ovf      <= 1'b0;
                    if (bus.enable) begin
                        state <= GATE;
                    end else begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.freq_count  = freq_q;
    assign bus.count_valid = valid_q;
    assign bus.overflow    = ovf_q;
    assign bus.busy        = busy_q;
endmodule
